// File: rtl/prt_encoder_pkg.sv
// Shared constants and helpers for the prt_encoder priority encoder.
package prt_encoder_pkg;

    localparam int PRT_ENC_DEFAULT_WIDTH = 4;

    // Reset value of the registered index and valid outputs.
    localparam int   PRT_ENC_RST_Y     = 0;
    localparam logic PRT_ENC_RST_VALID = 1'b0;

    // Index width needed to address WIDTH request bits.
    function automatic int prt_enc_out_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/prt_encoder_core.sv
// Purely combinational priority encoder: bit WIDTH-1 has highest priority.
module prt_encoder_core
    import prt_encoder_pkg::*;
#(
    parameter int WIDTH = PRT_ENC_DEFAULT_WIDTH,
    parameter int OUT_W = prt_enc_out_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    // Ascending scan: a later (higher) set bit overrides any lower one,
    // so the final value is the index of the highest set bit.
    always_comb begin
        y     = '0;
        valid = |i;
        for (int k = 0; k < WIDTH; k++) begin
            if (i[k]) begin
                y = OUT_W'(k);
            end
        end
    end

endmodule

// File: rtl/prt_encoder.sv
// prt_encoder top: combinational priority encoder plus optional output
// register. Define PRT_ENCODER_REG_OUT_EN to build the registered stage;
// otherwise y_q/valid_q are combinational copies of y/valid.
module prt_encoder
    import prt_encoder_pkg::*;
#(
    parameter int WIDTH = PRT_ENC_DEFAULT_WIDTH,
    parameter int OUT_W = prt_enc_out_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] y,
    output logic             valid,
    output logic [OUT_W-1:0] y_q,
    output logic             valid_q
);

    prt_encoder_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_core (
        .i     (i),
        .y     (y),
        .valid (valid)
    );

`ifdef PRT_ENCODER_REG_OUT_EN
    logic [OUT_W-1:0] y_p1;
    logic             vld_p1;

    // Output register stage: capture encoder result every edge, async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1   <= OUT_W'(PRT_ENC_RST_Y);
            vld_p1 <= PRT_ENC_RST_VALID;
        end else begin
            y_p1   <= y;
            vld_p1 <= valid;
        end
    end

    assign y_q     = y_p1;
    assign valid_q = vld_p1;
`else
    // No register stage: clock and reset are kept only for a stable port list.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign y_q     = y;
    assign valid_q = valid;
`endif

endmodule

// File: tb/tb_prt_encoder.sv
// Directed testbench for prt_encoder at WIDTH=4 and WIDTH=8.
module tb_prt_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] i4;
    logic [1:0] y4, y_q4;
    logic       valid4, valid_q4;
    logic [7:0] i8;
    logic [2:0] y8, y_q8;
    logic       valid8, valid_q8;

    int checks;
    int failures;

    prt_encoder #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i4),
        .y       (y4),
        .valid   (valid4),
        .y_q     (y_q4),
        .valid_q (valid_q4)
    );

    prt_encoder #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i8),
        .y       (y8),
        .valid   (valid8),
        .y_q     (y_q8),
        .valid_q (valid_q8)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: scan from the top bit down, first hit wins.
    function automatic int ref_idx(input logic [63:0] v, input int w);
        for (int k = w - 1; k >= 0; k--) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic comb4(input logic [3:0] v, input logic [1:0] ey, input logic ev);
        i4 = v;
        #5;
        check($sformatf("y4[%b]", v), 32'(y4), 32'(ey));
        check($sformatf("valid4[%b]", v), 32'(valid4), 32'(ev));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i4       = '0;
        i8       = '0;

        // Directed combinational vectors (reset held; y/valid unaffected).
        comb4(4'b0000, 2'b00, 1'b0);
        comb4(4'b0001, 2'b00, 1'b1);
        comb4(4'b0010, 2'b01, 1'b1);
        comb4(4'b0011, 2'b01, 1'b1);
        comb4(4'b0100, 2'b10, 1'b1);
        comb4(4'b0101, 2'b10, 1'b1);
        comb4(4'b0110, 2'b10, 1'b1);
        comb4(4'b0111, 2'b10, 1'b1);
        comb4(4'b1000, 2'b11, 1'b1);
        comb4(4'b1001, 2'b11, 1'b1);
        comb4(4'b1111, 2'b11, 1'b1);

        // Full sweep WIDTH=4.
        for (int v = 0; v < 16; v++) begin
            i4 = 4'(v);
            #5;
            check("sweep4_y", 32'(y4), 32'(ref_idx(64'(v), 4)));
            check("sweep4_valid", 32'(valid4), 32'(v != 0));
        end

        // Full sweep WIDTH=8 plus directed corners.
        for (int v = 0; v < 256; v++) begin
            i8 = 8'(v);
            #5;
            check("sweep8_y", 32'(y8), 32'(ref_idx(64'(v), 8)));
            check("sweep8_valid", 32'(valid8), 32'(v != 0));
        end
        i8 = 8'h80;
        #5;
        check("y8_80", 32'(y8), 32'd7);
        i8 = 8'h03;
        #5;
        check("y8_03", 32'(y8), 32'd1);

`ifdef PRT_ENCODER_REG_OUT_EN
        // Reset holds registered outputs at zero with no clock edge needed.
        @(negedge clk);
        rst_n = 1'b0;
        i4    = 4'b1111;
        #1;
        check("rst_y_q", 32'(y_q4), 32'd0);
        check("rst_valid_q", 32'(valid_q4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("load_y_q", 32'(y_q4), 32'd3);
        check("load_valid_q", 32'(valid_q4), 32'd1);

        // One-cycle latency: output holds until the next edge.
        @(negedge clk);
        i4 = 4'b0110;
        @(posedge clk);
        #1;
        check("lat_y_q_0110", 32'(y_q4), 32'd2);
        @(negedge clk);
        i4 = 4'b0001;
        #1;
        check("hold_y_q", 32'(y_q4), 32'd2);
        @(posedge clk);
        #1;
        check("next_y_q", 32'(y_q4), 32'd0);
        check("next_valid_q", 32'(valid_q4), 32'd1);

        // Mid-cycle asynchronous reset clears at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y_q", 32'(y_q4), 32'd0);
        check("async_valid_q", 32'(valid_q4), 32'd0);
`else
        // Pass-through build: registered outputs follow combinationally.
        i4 = 4'b0101;
        #1;
        check("pass_y_q", 32'(y_q4), 32'd2);
        check("pass_valid_q", 32'(valid_q4), 32'd1);
        i4 = 4'b0000;
        #1;
        check("pass_y_q_zero", 32'(y_q4), 32'd0);
        check("pass_valid_q_zero", 32'(valid_q4), 32'd0);
`endif

        // WIDTH=8 registered view after an edge out of reset.
        @(negedge clk);
        rst_n = 1'b1;
        i8    = 8'h41;
        @(posedge clk);
        #1;
        check("y_q8_41", 32'(y_q8), 32'd6);
        check("valid_q8_41", 32'(valid_q8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
